// File: rtl/alu_pkg.sv
// Shared opcode and FSM encodings for the multi-cycle ALU.
// Imported by alu_mc and its testbench.
package alu_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_MUL  = 3'b010;
  localparam logic [2:0] OP_RAND = 3'b011;
  localparam logic [2:0] OP_ASR  = 3'b100;
  localparam logic [2:0] OP_XOR  = 3'b101;
  localparam logic [2:0] OP_SHL  = 3'b110;
  localparam logic [2:0] OP_SHR  = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_MUL  = 2'b01,
    S_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier, one multiplier bit per clock, LSB first.
// The start edge performs the first iteration so the product is ready WIDTH edges later.
module alu_mul_iter #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] a_sh;
  logic [WIDTH-1:0]   b_sh;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] a_ext;

  assign a_ext   = {{WIDTH{1'b0}}, a};
  assign product = acc;

  // Accumulate one partial product per cycle; done pulses after the last bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc  <= '0;
      a_sh <= '0;
      b_sh <= '0;
      cnt  <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        acc  <= b[0] ? a_ext : '0;
        a_sh <= a_ext << 1;
        b_sh <= b >> 1;
        cnt  <= CW'(1);
        busy <= 1'b1;
      end else if (busy) begin
        acc  <= acc + (b_sh[0] ? a_sh : '0);
        a_sh <= a_sh << 1;
        b_sh <= b_sh >> 1;
        cnt  <= cnt + CW'(1);
        if (cnt == CW'(WIDTH - 1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Registered multi-cycle ALU with valid/ready on both sides.
// Single-cycle ops land in the result register on the accept edge; MUL iterates.
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic [2:0]         opcode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out,
  output logic               Sign_Flag,
  output logic               Zero_Flag
);

  localparam int SHW = $clog2(WIDTH);

  state_t             state;
  logic               accept;
  logic               mul_start;
  logic               mul_busy;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_prod;
  logic [2*WIDTH-1:0] res;
  logic [2*WIDTH-1:0] a_x;
  logic [2*WIDTH-1:0] b_x;
  logic [2*WIDTH-1:0] a_s;
  logic [SHW-1:0]     sh;

  assign accept    = in_valid && in_ready && (state == S_IDLE);
  assign mul_start = accept && (opcode == OP_MUL);
  assign a_x       = {{WIDTH{1'b0}}, A};
  assign b_x       = {{WIDTH{1'b0}}, B};
  assign a_s       = {{WIDTH{A[WIDTH-1]}}, A};
  assign sh        = B[SHW-1:0];

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (A),
    .b       (B),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_prod)
  );

  // Single-cycle datapath on the incoming operands.
  always_comb begin
    res = '0;
    unique case (1'b1)
      (opcode == OP_ADD):  res = a_x + b_x;
      (opcode == OP_SUB):  res = a_x - b_x;
      (opcode == OP_MUL):  res = '0;
      (opcode == OP_RAND): res = {{(2*WIDTH-1){1'b0}}, &A};
      (opcode == OP_ASR):  res = $signed(a_s) >>> sh;
      (opcode == OP_XOR):  res = a_x ^ b_x;
      (opcode == OP_SHL):  res = a_x << sh;
      (opcode == OP_SHR):  res = a_x >> sh;
      default:             res = '0;
    endcase
  end

  // Control FSM with registered handshake outputs, result and flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out       <= '0;
      Sign_Flag <= 1'b0;
      Zero_Flag <= 1'b1;
    end else begin
      unique case (state)
        S_IDLE: begin
          in_ready <= 1'b1;
          if (accept) begin
            in_ready <= 1'b0;
            if (opcode == OP_MUL) begin
              state <= S_MUL;
            end else begin
              state     <= S_DONE;
              out_valid <= 1'b1;
              out       <= res;
              Sign_Flag <= res[2*WIDTH-1];
              Zero_Flag <= (res == '0);
            end
          end
        end
        S_MUL: begin
          if (mul_done && !mul_busy) begin
            state     <= S_DONE;
            out_valid <= 1'b1;
            out       <= mul_prod;
            Sign_Flag <= mul_prod[2*WIDTH-1];
            Zero_Flag <= (mul_prod == '0);
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= S_IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: vector table through a scoreboard,
// plus hand sequences for stall, reset-mid-MUL and an 8-bit instance.
module tb_alu_mc;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] A;
  logic [31:0] B;
  logic [2:0]  opcode;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out;
  logic        Sign_Flag;
  logic        Zero_Flag;

  logic        in_valid8;
  logic        in_ready8;
  logic [7:0]  a8;
  logic [7:0]  b8;
  logic [2:0]  op8;
  logic        out_valid8;
  logic        out_ready8;
  logic [15:0] out8;
  logic        sign8;
  logic        zero8;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  logic ov_q = 1'b0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } vec_t;

  typedef struct {
    logic [63:0] exp;
    int          lat;
    int          acc;
  } sb_t;

  sb_t  sbq[$];
  vec_t vecs[16];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_mc #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .opcode    (opcode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .Sign_Flag (Sign_Flag),
    .Zero_Flag (Zero_Flag)
  );

  alu_mc #(.WIDTH(8)) dut8 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid8),
    .in_ready  (in_ready8),
    .A         (a8),
    .B         (b8),
    .opcode    (op8),
    .out_valid (out_valid8),
    .out_ready (out_ready8),
    .out       (out8),
    .Sign_Flag (sign8),
    .Zero_Flag (zero8)
  );

  // Scoreboard monitor: latency on first out_valid, value on handshake.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && !ov_q) begin
        tests++;
        if (sbq.size() == 0) begin
          fails++;
          $display("FAIL unexpected_result out=%h expected none", out);
        end else if (cyc - sbq[0].acc != sbq[0].lat) begin
          fails++;
          $display("FAIL latency got=%0d expected=%0d",
                   cyc - sbq[0].acc, sbq[0].lat);
        end
      end
      if (out_valid && out_ready && sbq.size() > 0) begin
        sb_t e;
        e = sbq.pop_front();
        tests++;
        if (out !== e.exp || Sign_Flag !== e.exp[63] ||
            Zero_Flag !== (e.exp == 64'd0)) begin
          fails++;
          $display("FAIL result out=%h S=%b Z=%b expected out=%h S=%b Z=%b",
                   out, Sign_Flag, Zero_Flag, e.exp, e.exp[63],
                   (e.exp == 64'd0));
        end
      end
    end
    ov_q = rst ? 1'b0 : out_valid;
  end

  task automatic check(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [63:0] exp,
                       input int lat);
    int n;
    n = 0;
    @(posedge clk); #1;
    in_valid = 1'b1;
    A = a;
    B = b;
    opcode = op;
    @(negedge clk);
    while (!in_ready) begin
      n++;
      if (n > 200) begin
        tests++;
        fails++;
        $display("FAIL accept_timeout in_ready=0 expected 1");
        in_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    sbq.push_back('{exp, lat, cyc});
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0) begin
      @(negedge clk);
      n++;
      if (n > 100) begin
        tests++;
        fails++;
        $display("FAIL drain_timeout pending=%0d expected 0", sbq.size());
        sbq.delete();
      end
    end
  endtask

  task automatic run8(input string name, input logic [2:0] op,
                      input logic [7:0] a, input logic [7:0] b,
                      input logic [15:0] exp, input int lat);
    int acc;
    int n;
    @(posedge clk); #1;
    in_valid8 = 1'b1;
    a8 = a;
    b8 = b;
    op8 = op;
    @(negedge clk);
    check({name, "_ready"}, {63'd0, in_ready8}, 64'd1);
    acc = cyc;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    n = 0;
    @(negedge clk);
    while (!out_valid8 && n < 40) begin
      n++;
      @(negedge clk);
    end
    check({name, "_lat"}, 64'(cyc - acc), 64'(lat));
    check({name, "_out"}, {48'd0, out8}, {48'd0, exp});
  endtask

  initial begin
    bit ok;
    int n;

    vecs[0]  = '{OP_ADD,  32'hFFFFFFFF, 32'h00000001, 64'h0000_0001_0000_0000};
    vecs[1]  = '{OP_SUB,  32'h00000000, 32'h00000001, 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[2]  = '{OP_XOR,  32'h5A5A5A5A, 32'h5A5A5A5A, 64'h0};
    vecs[3]  = '{OP_MUL,  32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFF_FFFE_0000_0001};
    vecs[4]  = '{OP_SHL,  32'h00000001, 32'h0000003F, 64'h0000_0000_8000_0000};
    vecs[5]  = '{OP_ASR,  32'h80000000, 32'h00000004, 64'hFFFF_FFFF_F800_0000};
    vecs[6]  = '{OP_RAND, 32'hFFFFFFFF, 32'h00000000, 64'h1};
    vecs[7]  = '{OP_RAND, 32'hFFFFFFFE, 32'h00000000, 64'h0};
    vecs[8]  = '{OP_SHR,  32'h80000000, 32'h00000024, 64'h0000_0000_0800_0000};
    vecs[9]  = '{OP_ADD,  32'h12345678, 32'h9ABCDEF0, 64'h0000_0000_ACF1_3568};
    vecs[10] = '{OP_SUB,  32'h00000005, 32'h00000003, 64'h2};
    vecs[11] = '{OP_MUL,  32'h00000003, 32'h00000005, 64'hF};
    vecs[12] = '{OP_XOR,  32'hF0F0F0F0, 32'h0FF00FF0, 64'h0000_0000_FF00_FF00};
    vecs[13] = '{OP_SHL,  32'hFFFFFFFF, 32'h00000004, 64'h0000_000F_FFFF_FFF0};
    vecs[14] = '{OP_ASR,  32'h40000000, 32'h0000001F, 64'h0};
    vecs[15] = '{OP_ASR,  32'h80000000, 32'h00000020, 64'hFFFF_FFFF_8000_0000};

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    A = '0;
    B = '0;
    opcode = OP_ADD;
    in_valid8 = 1'b0;
    out_ready8 = 1'b1;
    a8 = '0;
    b8 = '0;
    op8 = OP_ADD;

    #2;
    check("reset_out", out, 64'd0);
    check("reset_flags_vld", {61'd0, out_valid, Sign_Flag, Zero_Flag}, 64'b001);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_reset", {63'd0, in_ready}, 64'd1);

    foreach (vecs[i]) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp,
            (vecs[i].op == OP_MUL) ? 33 : 1);
      drain();
    end

    issue(OP_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFF_FFFE_0000_0001, 33);
    ok = 1'b1;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 60) begin
      if (in_ready) ok = 1'b0;
      n++;
      @(negedge clk);
    end
    check("mul_in_ready_low", {63'd0, ok}, 64'd1);
    drain();

    out_ready = 1'b0;
    issue(OP_ADD, 32'd1, 32'd2, 64'd3, 1);
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 20) begin
      n++;
      @(negedge clk);
    end
    @(posedge clk); #1;
    in_valid = 1'b1;
    A = 32'd7;
    B = 32'd8;
    opcode = OP_ADD;
    ok = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (out !== 64'd3 || Sign_Flag !== 1'b0 || Zero_Flag !== 1'b0 ||
          in_ready !== 1'b0 || out_valid !== 1'b1) ok = 1'b0;
    end
    check("stall_stable", {63'd0, ok}, 64'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("ready_after_handshake", {62'd0, in_ready, out_valid}, 64'b10);
    sbq.push_back('{64'd15, 1, cyc});
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain();

    issue(OP_MUL, 32'h12345678, 32'h00000009, 64'h0, 33);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    sbq.delete();
    check("rst_mid_mul_out", out, 64'd0);
    check("rst_mid_mul_ctl",
          {60'd0, out_valid, in_ready, Sign_Flag, Zero_Flag}, 64'b0001);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst_mid_mul", {63'd0, in_ready}, 64'd1);
    ok = 1'b1;
    repeat (50) begin
      @(negedge clk);
      if (out_valid) ok = 1'b0;
    end
    check("no_stale_result", {63'd0, ok}, 64'd1);

    run8("w8_mul", OP_MUL, 8'hFF, 8'hFF, 16'hFE01, 9);
    run8("w8_asr", OP_ASR, 8'h81, 8'h01, 16'hFFC0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
